// File: rtl/frame_draw_scheduler_pkg.sv
// Shared constants and types for the frame draw scheduler.
//   xMAX / yMAX     : last pixel column / row of the frame
//   UBYTE_W         : width of one position byte
//   FRAME_PIXELS    : total pixels in one frame
//   fsState_t       : scheduler states FS_IDLE, FS_LOAD, FS_SCAN, FS_DONE
package frame_draw_scheduler_pkg;

  localparam int unsigned xMAX         = 159;
  localparam int unsigned yMAX         = 119;
  localparam int unsigned UBYTE_W      = 8;
  localparam int unsigned PIX_CNT_W    = 15;
  localparam int unsigned FRAME_PIXELS = (xMAX + 1) * (yMAX + 1);

  typedef logic [UBYTE_W-1:0] ubyte_t;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_LOAD,
    FS_SCAN,
    FS_DONE
  } fsState_t;

endpackage

// File: rtl/frame_draw_scheduler_if.sv
// Renderer-side bus of the frame draw scheduler.
//   master (scheduler): drives render_restart, render_en and the frame
//                       snapshots; receives pix_valid.
//   slave  (renderer) : the mirror image.
interface frame_draw_scheduler_if;
  import frame_draw_scheduler_pkg::*;

  logic       pix_valid;
  logic       render_restart;
  logic       render_en;
  logic [3:0] game_state;
  ubyte_t     dino_y;
  ubyte_t     obs1_x;
  ubyte_t     obs1_h;
  ubyte_t     obs2_x;
  ubyte_t     obs2_h;

  modport master (
    input  pix_valid,
    output render_restart, render_en, game_state,
    output dino_y, obs1_x, obs1_h, obs2_x, obs2_h
  );

  modport slave (
    output pix_valid,
    input  render_restart, render_en, game_state,
    input  dino_y, obs1_x, obs1_h, obs2_x, obs2_h
  );
endinterface

// File: rtl/frame_draw_scheduler_tick_edge_queue.sv
// Frame tick rising-edge detector with a one-deep pending flag.
//   frame_tick : raw tick strobe
//   idle, done : scheduler is in IDLE / DONE
//   tickRise   : combinational rising edge of frame_tick
//   pending    : one queued tick
//   drop_cnt   : saturating dropped-tick count (FRAME_DROP_CNT_EN only)
module tick_edge_queue
  import frame_draw_scheduler_pkg::*;
(
  input  logic   clk,
  input  logic   resetn,
  input  logic   frame_tick,
  input  logic   idle,
  input  logic   done,
  output logic   tickRise,
  output logic   pending
`ifdef FRAME_DROP_CNT_EN
  ,
  output ubyte_t drop_cnt
`endif
);

  logic tickQ;
  logic consume;
  logic pendingNext;

  assign tickRise = frame_tick & ~tickQ;
  // A queued tick is consumed when the scheduler starts a frame from it
  // (DONE, or IDLE if a tick was queued during the DONE cycle). A tick
  // arriving in that same cycle takes its place.
  assign consume  = (idle | done) & pending;

  always_comb begin
    pendingNext = pending;
    if (consume)
      pendingNext = tickRise;
    else if (tickRise && !idle && !pending)
      pendingNext = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tickQ   <= 1'b0;
      pending <= 1'b0;
    end else begin
      tickQ   <= frame_tick;
      pending <= pendingNext;
    end
  end

`ifdef FRAME_DROP_CNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      drop_cnt <= '0;
    else if (tickRise && !idle && !consume && pending && drop_cnt != '1)
      drop_cnt <= drop_cnt + 1'b1;
  end
`endif

endmodule

// File: rtl/frame_draw_scheduler.sv
// Frame-level sequencer between game logic and the pixel renderer.
// On a frame tick it snapshots the game inputs, restarts and enables the
// renderer, counts plotted pixels to find end of frame and pulses
// frame_done. Mid-frame ticks queue one deep; further ticks are dropped.
// Optional macro FRAME_DROP_CNT_EN adds the drop_cnt port.
//   clk, resetn      : clock, asynchronous active-low reset
//   frame_tick       : frame strobe (edge detected)
//   *_in             : live game state / positions
//   rbus             : renderer bus (pix_valid in; restart/enable/snapshots out)
//   busy, frame_done : status
module frame_draw_scheduler
  import frame_draw_scheduler_pkg::*;
#(
  parameter int unsigned X_MAX = xMAX,
  parameter int unsigned Y_MAX = yMAX
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   frame_tick,
  input  logic [3:0]             game_state_in,
  input  ubyte_t                 dino_y_in,
  input  ubyte_t                 obs1_x_in,
  input  ubyte_t                 obs1_h_in,
  input  ubyte_t                 obs2_x_in,
  input  ubyte_t                 obs2_h_in,
  frame_draw_scheduler_if.master rbus,
  output logic                   busy,
  output logic                   frame_done
`ifdef FRAME_DROP_CNT_EN
  ,
  output ubyte_t                 drop_cnt
`endif
);

  localparam logic [PIX_CNT_W-1:0] LAST_PIX = PIX_CNT_W'((X_MAX + 1) * (Y_MAX + 1) - 1);

  fsState_t             state, stateNext;
  logic                 tickRise, pending;
  logic [PIX_CNT_W-1:0] pixCnt;
  logic                 renderRestart, renderEn;
  logic [3:0]           gameState;
  ubyte_t               dinoY, obs1X, obs1H, obs2X, obs2H;

  tick_edge_queue uQueue (
    .clk        (clk),
    .resetn     (resetn),
    .frame_tick (frame_tick),
    .idle       (state == FS_IDLE),
    .done       (state == FS_DONE),
    .tickRise   (tickRise),
    .pending    (pending)
`ifdef FRAME_DROP_CNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  always_comb begin
    stateNext = state;
    case (state)
      FS_IDLE: if (tickRise || pending) stateNext = FS_LOAD;
      FS_LOAD: stateNext = FS_SCAN;
      FS_SCAN: if (rbus.pix_valid && pixCnt == LAST_PIX) stateNext = FS_DONE;
      FS_DONE: stateNext = pending ? FS_LOAD : FS_IDLE;
      default: stateNext = FS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      state <= FS_IDLE;
    else
      state <= stateNext;
  end

  // Status outputs are registered from the next state so they line up
  // with the state they describe.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      renderRestart <= 1'b0;
      renderEn      <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      renderRestart <= (stateNext == FS_LOAD);
      renderEn      <= (stateNext == FS_SCAN);
      busy          <= (stateNext != FS_IDLE);
      frame_done    <= (stateNext == FS_DONE);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      pixCnt <= '0;
    else if (state == FS_LOAD)
      pixCnt <= '0;
    else if (state == FS_SCAN && rbus.pix_valid)
      pixCnt <= pixCnt + 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gameState <= '0;
      dinoY     <= '0;
      obs1X     <= '0;
      obs1H     <= '0;
      obs2X     <= '0;
      obs2H     <= '0;
    end else if (state == FS_LOAD) begin
      gameState <= game_state_in;
      dinoY     <= dino_y_in;
      obs1X     <= obs1_x_in;
      obs1H     <= obs1_h_in;
      obs2X     <= obs2_x_in;
      obs2H     <= obs2_h_in;
    end
  end

  assign rbus.render_restart = renderRestart;
  assign rbus.render_en      = renderEn;
  assign rbus.game_state     = gameState;
  assign rbus.dino_y         = dinoY;
  assign rbus.obs1_x         = obs1X;
  assign rbus.obs1_h         = obs1H;
  assign rbus.obs2_x         = obs2X;
  assign rbus.obs2_h         = obs2H;

endmodule
